// File: rtl/bp_fe_ltb.sv
// Loop termination buffer: learns loop trip counts per branch PC and predicts
// the exit iteration from a speculative iteration counter.
`timescale 1ns/1ps
module bp_fe_ltb #(
  parameter int unsigned vaddr_width_p   = 39,
  parameter int unsigned ltb_els_p       = 64,
  parameter int unsigned ltb_cnt_width_p = 8,
  parameter int unsigned ltb_tag_width_p = 10
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [vaddr_width_p-1:0]   r_addr_i,
  output logic                       pred_v_o,
  output logic                       pred_taken_o,
  output logic                       pred_conf_o,
  output logic [ltb_cnt_width_p-1:0] pred_non_spec_cnt_o,
  output logic [ltb_cnt_width_p-1:0] pred_trip_cnt_o,
  output logic [ltb_cnt_width_p-1:0] r_spec_cnt_o,
  input  logic                       w_v_i,
  input  logic [vaddr_width_p-1:0]   br_src_addr_i,
  input  logic                       br_taken_i,
  input  logic                       br_mispredict_i,
  output logic                       w_yumi_o,
  output logic                       w_conf_o,
  output logic [ltb_cnt_width_p-1:0] w_non_spec_cnt_o,
  output logic [ltb_cnt_width_p-1:0] w_trip_cnt_o,
  output logic [ltb_cnt_width_p-1:0] w_spec_cnt_o
);

  localparam int unsigned idx_width_lp = $clog2(ltb_els_p);
  localparam int unsigned tag_lsb_lp   = 2 + idx_width_lp;
  localparam int unsigned cnt_width_lp = ltb_cnt_width_p;

  typedef struct packed {
    logic                       valid;
    logic [ltb_tag_width_p-1:0] tag;
    logic                       conf;
    logic [cnt_width_lp-1:0]    non_spec_cnt;
    logic [cnt_width_lp-1:0]    trip_cnt;
    logic [cnt_width_lp-1:0]    spec_cnt;
  } ltb_entry_s;

  typedef enum logic {e_clear, e_ready} state_e;

  // Saturating increment; counters never wrap.
  function automatic logic [cnt_width_lp-1:0] sat_inc(input logic [cnt_width_lp-1:0] x);
    return (&x) ? x : x + cnt_width_lp'(1);
  endfunction

  state_e                  state_r, state_n;
  logic [idx_width_lp-1:0] clr_idx_r, clr_idx_n;
  ltb_entry_s              tbl_r [ltb_els_p];

  logic ready;
  assign ready       = (state_r == e_ready) & ~reset_i;
  assign init_done_o = ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_clear;
      clr_idx_r <= '0;
    end else begin
      state_r   <= state_n;
      clr_idx_r <= clr_idx_n;
    end
  end

  // Sweep every index once, then open the table for traffic.
  always_comb begin
    state_n   = state_r;
    clr_idx_n = clr_idx_r;
    if (state_r == e_clear) begin
      clr_idx_n = clr_idx_r + idx_width_lp'(1);
      if (clr_idx_r == idx_width_lp'(ltb_els_p - 1)) state_n = e_ready;
    end
  end

  logic [idx_width_lp-1:0]    r_idx, w_idx;
  logic [ltb_tag_width_p-1:0] r_tag, w_tag;
  ltb_entry_s                 rd, wr, w_new;
  logic                       r_fire, r_hit, r_taken;
  logic [cnt_width_lp-1:0]    r_spec_next;
  logic                       w_hit, w_alloc, w_write;

  assign r_idx = r_addr_i[2 +: idx_width_lp];
  assign r_tag = r_addr_i[tag_lsb_lp +: ltb_tag_width_p];
  assign w_idx = br_src_addr_i[2 +: idx_width_lp];
  assign w_tag = br_src_addr_i[tag_lsb_lp +: ltb_tag_width_p];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{r_addr_i[1:0], r_addr_i[vaddr_width_p-1:tag_lsb_lp+ltb_tag_width_p],
                              br_src_addr_i[1:0], br_src_addr_i[vaddr_width_p-1:tag_lsb_lp+ltb_tag_width_p]};

  assign rd          = tbl_r[r_idx];
  assign r_fire      = r_v_i & ready;
  assign r_hit       = rd.valid & (rd.tag == r_tag);
  assign r_taken     = r_hit & (rd.spec_cnt != rd.trip_cnt);
  assign r_spec_next = r_taken ? sat_inc(rd.spec_cnt) : '0;

  assign wr       = tbl_r[w_idx];
  assign w_hit    = wr.valid & (wr.tag == w_tag);
  assign w_yumi_o = w_v_i & ready & ~(r_v_i & (r_idx == w_idx));

  // Resolution update: learn trip count on loop exit, re-sync spec count on mispredict.
  always_comb begin
    w_new   = wr;
    w_alloc = 1'b0;
    if (w_hit) begin
      if (br_taken_i) begin
        w_new.non_spec_cnt = sat_inc(wr.non_spec_cnt);
        if (&wr.non_spec_cnt) w_new.valid = 1'b0;
      end else begin
        if (wr.non_spec_cnt == wr.trip_cnt) begin
          w_new.conf = 1'b1;
        end else begin
          w_new.conf     = 1'b0;
          w_new.trip_cnt = wr.non_spec_cnt;
        end
        w_new.non_spec_cnt = '0;
      end
      if (br_mispredict_i) w_new.spec_cnt = w_new.non_spec_cnt;
    end else if (br_taken_i) begin
      w_alloc            = 1'b1;
      w_new.valid        = 1'b1;
      w_new.tag          = w_tag;
      w_new.conf         = 1'b0;
      w_new.non_spec_cnt = cnt_width_lp'(1);
      w_new.trip_cnt     = '1;
      w_new.spec_cnt     = cnt_width_lp'(1);
    end
  end

  assign w_write          = w_yumi_o & (w_hit | w_alloc);
  assign w_conf_o         = w_write & w_new.conf;
  assign w_non_spec_cnt_o = w_write ? w_new.non_spec_cnt : '0;
  assign w_trip_cnt_o     = w_write ? w_new.trip_cnt     : '0;
  assign w_spec_cnt_o     = w_write ? w_new.spec_cnt     : '0;

  // Read and write never target the same index in one cycle (write is held off).
  always_ff @(posedge clk_i) begin
    if (~reset_i) begin
      if (state_r == e_clear) tbl_r[clr_idx_r].valid <= 1'b0;
      if (r_fire & r_hit)     tbl_r[r_idx].spec_cnt  <= r_spec_next;
      if (w_write)            tbl_r[w_idx]           <= w_new;
    end
  end

  logic                    pred_v_r, pred_taken_r, pred_conf_r;
  logic [cnt_width_lp-1:0] pred_ns_r, pred_trip_r, pred_spec_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pred_v_r     <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_conf_r  <= 1'b0;
      pred_ns_r    <= '0;
      pred_trip_r  <= '0;
      pred_spec_r  <= '0;
    end else begin
      pred_v_r     <= r_fire & r_hit;
      pred_taken_r <= r_fire & r_taken;
      pred_conf_r  <= r_fire & r_hit & rd.conf;
      pred_ns_r    <= (r_fire & r_hit) ? rd.non_spec_cnt : '0;
      pred_trip_r  <= (r_fire & r_hit) ? rd.trip_cnt     : '0;
      pred_spec_r  <= (r_fire & r_hit) ? rd.spec_cnt     : '0;
    end
  end

  // Outputs forced low for the whole reset window, including the assertion cycle.
  assign pred_v_o            = pred_v_r     & ~reset_i;
  assign pred_taken_o        = pred_taken_r & ~reset_i;
  assign pred_conf_o         = pred_conf_r  & ~reset_i;
  assign pred_non_spec_cnt_o = reset_i ? '0 : pred_ns_r;
  assign pred_trip_cnt_o     = reset_i ? '0 : pred_trip_r;
  assign r_spec_cnt_o        = reset_i ? '0 : pred_spec_r;

endmodule

// File: tb/tb_bp_fe_ltb.sv
// Directed bench for bp_fe_ltb with a per-cycle behavioural table model.
`timescale 1ns/1ps
module tb_bp_fe_ltb;
  localparam int VW = 39, ELS = 64, CW = 8, TW = 10, IW = 6, CMAX = 255;

  logic          clk, reset_i, init_done_o;
  logic          r_v_i, w_v_i, br_taken_i, br_mispredict_i;
  logic [VW-1:0] r_addr_i, br_src_addr_i;
  logic          pred_v_o, pred_taken_o, pred_conf_o, w_yumi_o, w_conf_o;
  logic [CW-1:0] pred_non_spec_cnt_o, pred_trip_cnt_o, r_spec_cnt_o;
  logic [CW-1:0] w_non_spec_cnt_o, w_trip_cnt_o, w_spec_cnt_o;

  bp_fe_ltb #(.vaddr_width_p(VW), .ltb_els_p(ELS), .ltb_cnt_width_p(CW), .ltb_tag_width_p(TW)) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i),
    .pred_v_o(pred_v_o), .pred_taken_o(pred_taken_o), .pred_conf_o(pred_conf_o),
    .pred_non_spec_cnt_o(pred_non_spec_cnt_o), .pred_trip_cnt_o(pred_trip_cnt_o),
    .r_spec_cnt_o(r_spec_cnt_o),
    .w_v_i(w_v_i), .br_src_addr_i(br_src_addr_i), .br_taken_i(br_taken_i),
    .br_mispredict_i(br_mispredict_i), .w_yumi_o(w_yumi_o), .w_conf_o(w_conf_o),
    .w_non_spec_cnt_o(w_non_spec_cnt_o), .w_trip_cnt_o(w_trip_cnt_o), .w_spec_cnt_o(w_spec_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one record per table slot, plain integers.
  bit m_valid [ELS];
  int m_tag [ELS], m_conf [ELS], m_ns [ELS], m_trip [ELS], m_spec [ELS];
  int since_rst = 0;
  bit seen_rst = 0;
  int e_pv = 0, e_pt = 0, e_pc = 0, e_pns = 0, e_ptrip = 0, e_rspec = 0;

  function automatic int idx_of(input longint a);
    return int'((a >> 2) % ELS);
  endfunction
  function automatic int tag_of(input longint a);
    return int'((a >> (2 + IW)) % (1 << TW));
  endfunction
  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  bit rdy, yumi, hit, wr_on, nv;
  int ri, rt, wi, wt, nc, nn, ntr, nsp;

  always @(negedge clk) begin : model
    if (reset_i) seen_rst = 1;
    if (seen_rst) begin
      rdy = !reset_i && since_rst >= ELS;
      check("init_done", init_done_o, rdy);
      check("pred_v", pred_v_o, reset_i ? 0 : e_pv);
      check("pred_taken", pred_taken_o, reset_i ? 0 : e_pt);
      check("pred_conf", pred_conf_o, reset_i ? 0 : e_pc);
      check("pred_ns", pred_non_spec_cnt_o, reset_i ? 0 : e_pns);
      check("pred_trip", pred_trip_cnt_o, reset_i ? 0 : e_ptrip);
      check("r_spec", r_spec_cnt_o, reset_i ? 0 : e_rspec);

      ri = idx_of(r_addr_i); rt = tag_of(r_addr_i);
      wi = idx_of(br_src_addr_i); wt = tag_of(br_src_addr_i);
      yumi = w_v_i && rdy && !(r_v_i && ri == wi);
      hit = m_valid[wi] && m_tag[wi] == wt;
      wr_on = 0; nv = 0; nc = 0; nn = 0; ntr = 0; nsp = 0;
      if (yumi && hit) begin
        wr_on = 1; nv = 1; nc = m_conf[wi]; nn = m_ns[wi]; ntr = m_trip[wi]; nsp = m_spec[wi];
        if (br_taken_i) begin
          if (nn == CMAX) nv = 0;
          nn = sat(nn);
        end else begin
          if (nn == ntr) nc = 1;
          else begin nc = 0; ntr = nn; end
          nn = 0;
        end
        if (br_mispredict_i) nsp = nn;
      end else if (yumi && br_taken_i) begin
        wr_on = 1; nv = 1; nc = 0; nn = 1; ntr = CMAX; nsp = 1;
      end
      check("w_yumi", w_yumi_o, yumi);
      check("w_conf", w_conf_o, wr_on ? nc : 0);
      check("w_ns", w_non_spec_cnt_o, wr_on ? nn : 0);
      check("w_trip", w_trip_cnt_o, wr_on ? ntr : 0);
      check("w_spec", w_spec_cnt_o, wr_on ? nsp : 0);

      // Advance the model across the coming rising edge.
      if (reset_i) begin
        since_rst = 0;
        e_pv = 0; e_pt = 0; e_pc = 0; e_pns = 0; e_ptrip = 0; e_rspec = 0;
      end else begin
        if (!rdy) begin
          m_valid[since_rst] = 0;
          since_rst++;
        end
        e_pv = 0; e_pt = 0; e_pc = 0; e_pns = 0; e_ptrip = 0; e_rspec = 0;
        if (r_v_i && rdy && m_valid[ri] && m_tag[ri] == rt) begin
          e_pv = 1; e_pt = (m_spec[ri] != m_trip[ri]) ? 1 : 0;
          e_pc = m_conf[ri]; e_pns = m_ns[ri]; e_ptrip = m_trip[ri]; e_rspec = m_spec[ri];
          m_spec[ri] = e_pt ? sat(m_spec[ri]) : 0;
        end
        if (wr_on) begin
          m_valid[wi] = nv; m_tag[wi] = wt; m_conf[wi] = nc;
          m_ns[wi] = nn; m_trip[wi] = ntr; m_spec[wi] = nsp;
        end
      end
    end
  end

  task automatic drive(input bit rv, input longint ra, input bit wv, input longint wa,
                       input bit tk, input bit mp);
    r_v_i = rv; r_addr_i = VW'(ra);
    w_v_i = wv; br_src_addr_i = VW'(wa);
    br_taken_i = tk; br_mispredict_i = mp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_t [5] = '{1, 1, 1, 0, 1};
  int exp_s [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    reset_i = 1'b0;

    // Init sweep timing and an ignored early read.
    for (int c = 0; c <= 64; c++) begin
      drive(c == 10, 64'h1000, 0, 0, 0, 0);
      #3;
      if (c == 0)  check("init_c0", init_done_o, 0);
      if (c == 63) check("init_c63", init_done_o, 0);
      if (c == 64) check("init_c64", init_done_o, 1);
      if (c == 11) check("early_read_pred_v", pred_v_o, 0);
      tick();
    end

    // Train 0x1000 with T,T,T,N twice; exit resolutions flagged as mispredicts.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 4; k++) begin
        drive(0, 0, 1, 64'h1000, k < 3, k == 3);
        #3;
        check("train_yumi", w_yumi_o, 1);
        if (rep == 0 && k == 0) begin
          check("alloc_ns", w_non_spec_cnt_o, 1);
          check("alloc_trip", w_trip_cnt_o, CMAX);
        end
        if (k == 3) begin
          check("train_trip", w_trip_cnt_o, 3);
          check("train_conf", w_conf_o, rep);
          check("train_ns", w_non_spec_cnt_o, 0);
        end
        tick();
      end
    end

    // Back-to-back reads walk the speculative count through the loop.
    for (int k = 0; k <= 5; k++) begin
      drive(k < 5, 64'h1000, 0, 0, 0, 0);
      #3;
      if (k > 0) begin
        check("rd_hit", pred_v_o, 1);
        check("rd_taken", pred_taken_o, exp_t[k-1]);
        check("rd_spec", r_spec_cnt_o, exp_s[k-1]);
        check("rd_conf", pred_conf_o, 1);
        check("rd_trip", pred_trip_cnt_o, 3);
      end
      tick();
    end

    // One more read takes spec to 2, then a taken mispredict resyncs it.
    drive(1, 64'h1000, 0, 0, 0, 0);
    #3;
    tick();
    drive(0, 0, 1, 64'h1000, 1, 1);
    #3;
    check("pre_misp_spec", r_spec_cnt_o, 1);
    check("misp_ns", w_non_spec_cnt_o, 1);
    check("misp_spec", w_spec_cnt_o, 1);
    tick();

    // Same-index read blocks the write for one cycle.
    drive(1, 64'h1000, 1, 64'h2000, 0, 0);
    #3;
    check("conflict_yumi", w_yumi_o, 0);
    tick();
    drive(0, 0, 1, 64'h2000, 0, 0);
    #3;
    check("retry_yumi", w_yumi_o, 1);
    check("nt_miss_ns", w_non_spec_cnt_o, 0);
    tick();

    // Committed count saturates, then the next taken invalidates the entry.
    for (int n = 0; n < 256; n++) begin
      drive(0, 0, 1, 64'h3004, 1, 0);
      #3;
      if (n == 254) check("sat_ns_reach", w_non_spec_cnt_o, CMAX);
      if (n == 255) check("sat_ns_hold", w_non_spec_cnt_o, CMAX);
      tick();
    end
    drive(1, 64'h3004, 0, 0, 0, 0);
    #3;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    check("sat_invalid_pred_v", pred_v_o, 0);
    tick();

    // Reset with a hit in flight: outputs drop, sweep restarts, table empty.
    drive(1, 64'h1000, 0, 0, 0, 0);
    #3;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    reset_i = 1'b1;
    #3;
    check("rst_pred_v", pred_v_o, 0);
    check("rst_init", init_done_o, 0);
    tick();
    reset_i = 1'b0;
    for (int c = 0; c <= 64; c++) begin
      #3;
      if (c == 63) check("reinit_c63", init_done_o, 0);
      if (c == 64) check("reinit_c64", init_done_o, 1);
      tick();
    end
    drive(1, 64'h1000, 0, 0, 0, 0);
    #3;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    check("post_rst_pred_v", pred_v_o, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bp_fe_ltb.md
BP_FE_LTB -- requirements
Module: bp_fe_ltb

Interface
REQ-001 Parameter vaddr_width_p, default 39, virtual address width.
REQ-002 Parameter ltb_els_p, default 64, number of entries; power of two, at least 2.
REQ-003 Parameter ltb_cnt_width_p, default 8, width of every loop counter.
REQ-004 Parameter ltb_tag_width_p, default 10, tag width.
REQ-005 Ports, in order:
- clk_i  in  1  clock
- reset_i  in  1  reset
- init_done_o  out  1  table cleared, block ready
- r_v_i  in  1  fetch lookup request
- r_addr_i  in  vaddr_width_p  lookup PC
- pred_v_o  out  1  hit, registered
- pred_taken_o  out  1  predicted taken
- pred_conf_o  out  1  entry confident
- pred_non_spec_cnt_o  out  ltb_cnt_width_p  committed count
- pred_trip_cnt_o  out  ltb_cnt_width_p  learned trip count
- r_spec_cnt_o  out  ltb_cnt_width_p  speculative count used for the prediction
- w_v_i  in  1  branch resolution valid
- br_src_addr_i  in  vaddr_width_p  resolved branch PC
- br_taken_i  in  1  resolved direction
- br_mispredict_i  in  1  resolution was a mispredict
- w_yumi_o  out  1  resolution consumed this cycle
- w_conf_o, w_non_spec_cnt_o, w_trip_cnt_o, w_spec_cnt_o  out  1/cnt/cnt/cnt  values written this cycle
REQ-006 One clock, clk_i; reset_i is synchronous and active-high.

Function
REQ-007 Index = addr[2 +: log2(ltb_els_p)]; tag = addr[2+log2(ltb_els_p) +: ltb_tag_width_p].
REQ-008 Each entry holds: valid, tag, conf, non_spec_cnt, trip_cnt, spec_cnt.
REQ-009 Init FSM states are e_clear and e_ready.
- Reset enters e_clear with index counter 0.
- e_clear invalidates one entry per cycle.
- After the last index, the FSM moves to e_ready.
- init_done_o = (state == e_ready).
REQ-010 Reads and writes are ignored while init_done_o=0: no state change, w_yumi_o=0.
REQ-011 A read accepted in cycle N (r_v_i & init_done_o) produces outputs in cycle N+1; latency is 1.
- pred_v_o = valid & tag match.
- pred_taken_o = pred_v_o & (spec_cnt != trip_cnt).
- pred_conf_o = conf; pred_non_spec_cnt_o = non_spec_cnt; pred_trip_cnt_o = trip_cnt.
- r_spec_cnt_o = spec_cnt before update.
REQ-012 When there was no accepted read in cycle N, or on a miss, all pred_* outputs and r_spec_cnt_o are 0 in N+1.
REQ-013 Read hit speculative update in cycle N: if predicted taken, spec_cnt += 1 (saturating); else spec_cnt = 0.
REQ-014 w_yumi_o = w_v_i & init_done_o & ~(r_v_i & read index == write index); the write takes effect only when w_yumi_o=1.
REQ-015 Write miss:
- If br_taken_i, allocate: valid=1, tag, conf=0, non_spec_cnt=1, spec_cnt=1, trip_cnt=all-ones.
- If not taken, no change.
REQ-016 Write hit, taken: non_spec_cnt += 1. If non_spec_cnt is already all-ones, the entry is invalidated.
REQ-017 Write hit, not taken:
- If non_spec_cnt == trip_cnt, conf=1.
- Otherwise conf=0 and trip_cnt = non_spec_cnt.
- In both cases non_spec_cnt = 0.
REQ-018 On a hit with br_mispredict_i=1, spec_cnt = the new non_spec_cnt; otherwise spec_cnt is unchanged by writes.
REQ-019 When w_yumi_o=1, w_conf_o, w_non_spec_cnt_o, w_trip_cnt_o and w_spec_cnt_o carry the post-update entry values combinationally. They are 0 on a non-allocating miss and 0 when w_yumi_o=0.
REQ-020 All counter arithmetic is modulo-free and saturating at ltb_cnt_width_p bits; no wrap-around is permitted.

Reset
REQ-021 While reset_i=1, all outputs are 0 and state is e_clear.
REQ-022 Reset asserted mid-operation discards any in-flight read output. Clearing restarts at index 0 and all entries are invalid after re-init.

Verification (ltb_els_p=64, ltb_cnt_width_p=8)
REQ-023 Reset deasserted before cycle 0 -> init_done_o=0 for cycles 0..63 and 1 from cycle 64; r_v_i at cycle 10 -> pred_v_o=0 at cycle 11.
REQ-024 Train addr 0x1000 with T,T,T,N -> after N: trip_cnt=3, conf=0, non_spec_cnt=0. Repeat T,T,T,N -> conf=1, trip_cnt=3.
REQ-025 After REQ-024 training, four reads of 0x1000 -> pred_taken_o=1,1,1,0 with r_spec_cnt_o=0,1,2,3; a fifth read -> taken, r_spec_cnt_o=0.
REQ-026 Same-cycle r_v_i at 0x1000 and w_v_i at 0x2000 (same index 0) -> w_yumi_o=0; next cycle with r_v_i=0 -> w_yumi_o=1.
REQ-027 Entry with spec_cnt=2, non_spec_cnt=0; write taken with br_mispredict_i=1 -> w_non_spec_cnt_o=1, w_spec_cnt_o=1.
REQ-028 Reset pulsed for 1 cycle after training -> 64 clear cycles, then a read of 0x1000 gives pred_v_o=0.
